// File: rtl/aes_gf_pkg.sv
// aes_gf_pkg
// Shared types, constants and GF(2^8) helpers for the AES MixColumns engine.
// No ports: imported by gf_mixcol_column and mix_columns_engine.
//   aes_byte_t / aes_col_t / aes_state_t : byte, 32-bit column, 128-bit state
//   AES_POLY_LOW                         : low byte of x^8+x^4+x^3+x+1
//   xtime, gf_mul9/11/13/14              : constant multipliers over GF(2^8)
//   mc_state_e                           : engine control states
package aes_gf_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  localparam aes_byte_t AES_POLY_LOW = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Multiply by x: shift left, reduce by the field polynomial when a bit falls off.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LOW : 8'h00);
  endfunction

  // 9 = 8 + 1
  function automatic aes_byte_t gf_mul9(input aes_byte_t b);
    aes_byte_t b8;
    b8 = xtime(xtime(xtime(b)));
    return b8 ^ b;
  endfunction

  // 11 = 8 + 2 + 1
  function automatic aes_byte_t gf_mul11(input aes_byte_t b);
    aes_byte_t b2;
    aes_byte_t b8;
    b2 = xtime(b);
    b8 = xtime(xtime(b2));
    return b8 ^ b2 ^ b;
  endfunction

  // 13 = 8 + 4 + 1
  function automatic aes_byte_t gf_mul13(input aes_byte_t b);
    aes_byte_t b4;
    aes_byte_t b8;
    b4 = xtime(xtime(b));
    b8 = xtime(b4);
    return b8 ^ b4 ^ b;
  endfunction

  // 14 = 8 + 4 + 2
  function automatic aes_byte_t gf_mul14(input aes_byte_t b);
    aes_byte_t b2;
    aes_byte_t b4;
    aes_byte_t b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return b8 ^ b4 ^ b2;
  endfunction

endpackage

// File: rtl/gf_mixcol_column.sv
// gf_mixcol_column
// Purely combinational transform of one 32-bit AES column.
// Ports:
//   col     in  32  column, row 0 in bits [31:24]
//   inv     in  1   0 = MixColumns [02 03 01 01], 1 = InvMixColumns [0E 0B 0D 09]
//   col_out out 32  transformed column, same byte layout
module gf_mixcol_column
  import aes_gf_pkg::*;
(
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] col_out
);

  aes_byte_t a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Each output row is the circulant matrix row times the column; 03*a is xtime(a)^a.
  always_comb begin
    col_out = '0;
    if (inv) begin
      col_out = {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                 gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                 gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                 gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    end else begin
      col_out = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// mix_columns_engine
// Handshaked AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns
// per clock, so a block takes 4/COLS_PER_CYCLE work cycles.
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    input handshake; in_data (128) and in_inv sampled on accept
//   out_valid/out_ready  output handshake; out_data (128) and out_inv are registered
// Column c of the state is bits [127-32c -: 32].
module mix_columns_engine
  import aes_gf_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inv
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // For 4 columns per cycle the step truncates to 0, but that path is never
  // taken because the single group is always the last one.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  mc_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t work_q, work_d;
  logic       inv_q, inv_d;
  aes_state_t out_data_q, out_data_d;
  logic       out_inv_q, out_inv_d;

  logic       accept;
  logic       last_group;
  aes_col_t   col_in  [COLS_PER_CYCLE];
  aes_col_t   col_res [COLS_PER_CYCLE];

  // Column mux: pick the group of columns starting at cnt from the working register.
  always_comb begin
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_in[g] = work_q[127 - 32*(int'(cnt_q) + g) -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    gf_mixcol_column u_col (
      .col     (col_in[g]),
      .inv     (inv_q),
      .col_out (col_res[g])
    );
  end

  assign last_group = (int'(cnt_q) + COLS_PER_CYCLE) == 4;

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      inv_q      <= 1'b0;
      out_data_q <= '0;
      out_inv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      inv_q      <= inv_d;
      out_data_q <= out_data_d;
      out_inv_q  <= out_inv_d;
    end
  end

  // Next state. Columns are rewritten in place; the finished state is copied
  // into the output register so out_data never shows a partly transformed block.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    inv_d      = inv_q;
    out_data_d = out_data_q;
    out_inv_d  = out_inv_q;
    accept     = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          work_d[127 - 32*(int'(cnt_q) + g) -: 32] = col_res[g];
        end
        if (last_group) begin
          cnt_d      = '0;
          out_data_d = work_d;
          out_inv_d  = inv_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      DONE: begin
        // Handoff and a new accept may share the same cycle.
        if (out_ready) begin
          if (accept) begin
            work_d  = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
  end

  assign out_data = out_data_q;
  assign out_inv  = out_inv_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine
// Directed bench for mix_columns_engine. Three instances (1, 2 and 4 columns
// per cycle) share the input side; each has its own outputs.
module tb_mix_columns_engine;

  localparam logic [127:0] STATE_A = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] STATE_B = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] COL_IN  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] COL_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic [127:0] inData;
  logic         inInv;
  logic         outReady;

  logic         inReady1, outValid1, outInv1;
  logic         inReady2, outValid2, outInv2;
  logic         inReady4, outValid4, outInv4;
  logic [127:0] outData1, outData2, outData4;

  int           checkCount = 0;
  int           errorCount = 0;

  int           lat1, lat2, lat4;
  logic [127:0] res1, res2, res4;
  logic         rinv1, rinv2, rinv4;
  int           latToggle;
  logic         sawValid;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady1),
    .in_data(inData), .in_inv(inInv), .out_valid(outValid1),
    .out_ready(outReady), .out_data(outData1), .out_inv(outInv1)
  );

  mix_columns_engine #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady2),
    .in_data(inData), .in_inv(inInv), .out_valid(outValid2),
    .out_ready(outReady), .out_data(outData2), .out_inv(outInv2)
  );

  mix_columns_engine #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady4),
    .in_data(inData), .in_inv(inInv), .out_valid(outValid4),
    .out_ready(outReady), .out_data(outData4), .out_inv(outInv4)
  );

  // Advance one clock and settle away from the edge.
  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  // Drive the shared input side.
  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic inv, input logic rdy);
    inValid  = v;
    inData   = d;
    inInv    = inv;
    outReady = rdy;
  endtask

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // After an accept edge, record the first cycle each instance shows out_valid.
  task automatic waitAll();
    lat1 = 0; lat2 = 0; lat4 = 0;
    res1 = '0; res2 = '0; res4 = '0;
    rinv1 = 1'b0; rinv2 = 1'b0; rinv4 = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      stepClock();
      if (outValid1 && lat1 == 0) begin lat1 = cyc; res1 = outData1; rinv1 = outInv1; end
      if (outValid2 && lat2 == 0) begin lat2 = cyc; res2 = outData2; rinv2 = outInv2; end
      if (outValid4 && lat4 == 0) begin lat4 = cyc; res4 = outData4; rinv4 = outInv4; end
    end
  endtask

  task automatic checkAll(input string tag, input logic [127:0] expData, input logic expInv);
    checkOutput({tag, " latency c1"}, 128'(lat1), 128'd4);
    checkOutput({tag, " latency c2"}, 128'(lat2), 128'd2);
    checkOutput({tag, " latency c4"}, 128'(lat4), 128'd1);
    checkOutput({tag, " data c1"}, res1, expData);
    checkOutput({tag, " data c2"}, res2, expData);
    checkOutput({tag, " data c4"}, res4, expData);
    checkOutput({tag, " inv c1"}, 128'(rinv1), 128'(expInv));
    checkOutput({tag, " inv c2"}, 128'(rinv2), 128'(expInv));
    checkOutput({tag, " inv c4"}, 128'(rinv4), 128'(expInv));
  endtask

  // While instance 1 is busy, keep in_valid high with junk data and a toggling
  // in_inv; stop on the cycle its result appears.
  task automatic waitToggle(output int lat);
    lat = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      applyStimulus(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, cyc[0], 1'b1);
      stepClock();
      if (outValid1) begin
        lat = cyc;
        break;
      end
    end
  endtask

  initial begin
    $display("[TB] mix_columns_engine bench start");
    rstN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    stepClock();
    stepClock();

    // Reset state
    checkOutput("reset in_ready", 128'(inReady1), 128'd0);
    checkOutput("reset out_valid", 128'(outValid1), 128'd0);
    checkOutput("reset out_data", outData1, '0);
    checkOutput("reset out_inv", 128'(outInv1), 128'd0);
    rstN = 1'b1;
    stepClock();
    checkOutput("idle in_ready c1", 128'(inReady1), 128'd1);
    checkOutput("idle in_ready c2", 128'(inReady2), 128'd1);
    checkOutput("idle in_ready c4", 128'(inReady4), 128'd1);

    // Forward and inverse round trip on the full state, all widths
    applyStimulus(1'b1, STATE_A, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("forward", STATE_B, 1'b0);

    applyStimulus(1'b1, STATE_B, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("inverse", STATE_A, 1'b1);

    // Individual column vectors, forward then back
    applyStimulus(1'b1, COL_IN, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("columns fwd", COL_OUT, 1'b0);

    applyStimulus(1'b1, COL_OUT, 1'b1, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("columns inv", COL_IN, 1'b1);

    // Backpressure: result held 10 cycles with a second block pending
    applyStimulus(1'b1, STATE_A, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, STATE_B, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) stepClock();
    for (int i = 0; i < 10; i++) begin
      checkOutput("backpressure out_valid", 128'(outValid1), 128'd1);
      checkOutput("backpressure out_data", outData1, STATE_B);
      checkOutput("backpressure in_ready", 128'(inReady1), 128'd0);
      stepClock();
    end
    checkOutput("backpressure out_inv", 128'(outInv1), 128'd0);
    applyStimulus(1'b1, STATE_B, 1'b1, 1'b1);
    #1;
    checkOutput("release in_ready", 128'(inReady1), 128'd1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("second block", STATE_A, 1'b1);

    // Mode isolation on back-to-back blocks, in_inv toggling while busy
    applyStimulus(1'b1, STATE_A, 1'b0, 1'b1);
    stepClock();
    waitToggle(latToggle);
    checkOutput("mode blk1 latency", 128'(latToggle), 128'd4);
    checkOutput("mode blk1 data", outData1, STATE_B);
    checkOutput("mode blk1 inv", 128'(outInv1), 128'd0);

    applyStimulus(1'b1, STATE_B, 1'b1, 1'b1);
    stepClock();
    waitToggle(latToggle);
    checkOutput("mode blk2 latency", 128'(latToggle), 128'd4);
    checkOutput("mode blk2 data", outData1, STATE_A);
    checkOutput("mode blk2 inv", 128'(outInv1), 128'd1);

    applyStimulus(1'b1, COL_IN, 1'b0, 1'b1);
    stepClock();
    waitToggle(latToggle);
    checkOutput("mode blk3 latency", 128'(latToggle), 128'd4);
    checkOutput("mode blk3 data", outData1, COL_OUT);
    checkOutput("mode blk3 inv", 128'(outInv1), 128'd0);

    applyStimulus(1'b1, COL_OUT, 1'b1, 1'b1);
    stepClock();
    waitToggle(latToggle);
    checkOutput("mode blk4 latency", 128'(latToggle), 128'd4);
    checkOutput("mode blk4 data", outData1, COL_IN);
    checkOutput("mode blk4 inv", 128'(outInv1), 128'd1);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) stepClock();

    // Reset in the middle of a block (cnt = 2 on the 1-column instance)
    applyStimulus(1'b1, STATE_A, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    stepClock();
    stepClock();
    rstN = 1'b0;
    stepClock();
    checkOutput("mid reset in_ready", 128'(inReady1), 128'd0);
    checkOutput("mid reset out_valid", 128'(outValid1), 128'd0);
    checkOutput("mid reset out_data", outData1, '0);
    checkOutput("mid reset out_inv", 128'(outInv1), 128'd0);
    rstN = 1'b1;
    stepClock();
    checkOutput("after reset in_ready", 128'(inReady1), 128'd1);
    checkOutput("after reset out_valid", 128'(outValid1), 128'd0);
    checkOutput("after reset out_data", outData1, '0);
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stepClock();
      if (outValid1 || outValid2 || outValid4) sawValid = 1'b1;
    end
    checkOutput("aborted block absent", 128'(sawValid), 128'd0);

    // The engine still works normally after the abort
    applyStimulus(1'b1, STATE_A, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    waitAll();
    checkAll("post reset", STATE_B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Parametrised, handshaked AES MixColumns engine that applies either the forward MixColumns matrix [02 03 01 01] or the inverse matrix [0E 0B 0D 09] over GF(2^8) to a 128-bit state. It processes COLS_PER_CYCLE columns per clock, which trades area for latency. It sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath, so encryption and decryption share one block. Mode is selected per transaction, not per build.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data/in_inv are valid.
- in_ready  output  1  engine can accept a block.
- in_data  input  128  state; column c = bits [127-32c -: 32]; row r of a column = column bits [31-8r -: 8].
- in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled on accept.
- out_valid  output  1  out_data/out_inv are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  128  transformed state, same byte layout as in_data.
- out_inv  output  1  mode used for the block in out_data.

## Operation
- N = 4 / COLS_PER_CYCLE work cycles per block.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On accept (in_valid&&in_ready), the engine captures in_data into the working register, captures in_inv into the mode register, clears the column counter and moves to BUSY.
- BUSY: in_ready=0. Each cycle the engine replaces columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working register in place with their transform, then adds COLS_PER_CYCLE to cnt. When the last group is written, the state moves to DONE.
- DONE: out_valid=1 and the output holds stable until out_ready. in_ready=out_ready, so handoff and a new accept can occur in the same cycle. On out_ready with in_valid, the next block is accepted and the state goes to BUSY. On out_ready without in_valid, the state goes to IDLE.
- Multiplication uses xtime: shift left by 1, then XOR 0x1B if the old MSB was 1. Constants 09/0B/0D/0E are built from xtime chains. All arithmetic is 8-bit XOR; there are no carries.
- in_data and in_inv are ignored when no accept occurs. Changing in_inv mid-block has no effect.
- Reset mid-operation discards the block in flight. No partial result is ever presented.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 from the first cycle after release. out_valid=0, out_data=0, out_inv=0, state=IDLE, cnt=0.
- Latency: accept at edge T, out_valid=1 after edge T+N. This is 4, 2 or 1 cycles for COLS_PER_CYCLE = 1, 2, 4.
- Throughput: one block per N cycles under continuous in_valid/out_ready.
- Backpressure: out_data and out_inv stay constant while out_valid&&!out_ready. No accept occurs while !out_ready.
- out_data is registered; there is no combinational path from in_data to out_data.

## Structure
- Package aes_gf_pkg holds:
  - typedef aes_byte_t [7:0], aes_col_t [31:0], aes_state_t [127:0];
  - the constant AES_POLY_LOW = 8'h1B;
  - functions xtime, gf_mul9/11/13/14;
  - the state enum {IDLE, BUSY, DONE}.
- Sub-module gf_mixcol_column: a purely combinational single-column transform with inputs col (32) and inv (1) and output col_out (32). It is instantiated COLS_PER_CYCLE times and driven by a column mux indexed by cnt.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_data=d4bf5d30e0b452aeb84111f11e2798e5, in_inv=0 -> out_data=046681e5e0cb199a48f8d37a2806264c exactly 4 cycles after accept, out_inv=0.
- Inverse round-trip: in_data=046681e5e0cb199a48f8d37a2806264c, in_inv=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5. Repeat for COLS_PER_CYCLE=2 and 4 and check latency 2 and 1.
- Column vectors, forward: db135345->8e4da1bc, f20a225c->9fdc589d, c6c6c6c6->c6c6c6c6, d4d4d4d5->d5d5d7d6. The inverse of each output returns the input.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and a second block pending. out_data stays stable and in_ready=0. When out_ready=1, the second block is accepted in that cycle and its result appears N cycles later.
- Mode isolation: alternate in_inv 0/1 on back-to-back blocks and toggle in_inv while BUSY. Each out_inv and out_data matches the mode sampled at its own accept.
- Reset mid-BUSY: assert rst_n=0 for one cycle at cnt=2. Then out_valid=0, out_data=0 and in_ready=1 next cycle, and the aborted block never appears.
